// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_seq
//  Purpose  : Command sequencer in front of LCD_CTRL. Buffers 4-bit
//             image-processing commands in a circular FIFO and issues them
//             one at a time on cmd/cmd_valid, honouring busy. After a Write
//             command (code 0) issue is held until done, then frame_done
//             pulses.
//  Options  : CMD_FILTER_EN - when defined, codes 0xC..0xF are popped and
//             dropped (counted in illegal_cnt) instead of being issued.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_seq #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                host_cmd,
    input  logic                      host_push,
    output logic                      host_full,
    output logic [$clog2(DEPTH):0]    host_count,
    output logic                      overflow,
    output logic [3:0]                cmd,
    output logic                      cmd_valid,
    input  logic                      busy,
    input  logic                      done,
    output logic                      frame_done,
    output logic [CNT_W-1:0]          issued_cnt,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic [CNT_W-1:0]          illegal_cnt
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL     = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_OCC_ONE  = (c_AW+1)'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_SETTLE    = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [3:0]         r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               r_overflow;
    logic [3:0]         r_cmd;
    logic               r_frame_done;
    logic [CNT_W-1:0]   r_issued_cnt;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop;
    logic [3:0]         w_head;
    logic               w_issue_load;
    logic               w_frame_end;

    // Full is judged on the registered occupancy only, so a pop in the same
    // cycle never makes room for a push.
    assign w_empty    = (r_count == '0);
    assign host_full  = (r_count == c_FULL);
    assign host_count = r_count;
    assign overflow   = r_overflow;
    assign cmd        = r_cmd;
    assign frame_done = r_frame_done;
    assign issued_cnt = r_issued_cnt;
    assign frame_cnt  = r_frame_cnt;
    assign w_push_ok  = host_push & ~host_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_pop      = (r_state == S_IDLE) & ~w_empty & ~busy;

`ifdef CMD_FILTER_EN
    logic               w_illegal;
    logic               w_illegal_drop;
    logic [CNT_W-1:0]   r_illegal_cnt;

    assign w_illegal   = (w_head[3:2] == 2'b11);
    assign illegal_cnt = r_illegal_cnt;

    // Count entries that were popped but discarded as illegal codes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_cnt <= '0;
        end else if (w_illegal_drop) begin
            r_illegal_cnt <= r_illegal_cnt + c_CNT_ONE;
        end
    end
`else
    assign illegal_cnt = '0;
`endif

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= host_cmd;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + c_OCC_ONE;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - c_OCC_ONE;
            end
            if (host_push && host_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode for the issue sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue_load = 1'b0;
        w_frame_end  = 1'b0;
        cmd_valid    = 1'b0;
`ifdef CMD_FILTER_EN
        w_illegal_drop = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
`ifdef CMD_FILTER_EN
                    if (w_illegal) begin
                        w_illegal_drop = 1'b1;
                    end else begin
                        w_issue_load = 1'b1;
                        w_state_nxt  = S_ISSUE;
                    end
`else
                    w_issue_load = 1'b1;
                    w_state_nxt  = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                cmd_valid   = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            // Dead cycle: LCD_CTRL raises busy one cycle after acceptance.
            S_SETTLE: begin
                w_state_nxt = (r_cmd == 4'd0) ? S_WAIT_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            // busy is deliberately ignored while a frame write is in flight.
            S_WAIT_DONE: begin
                if (done) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Issued command register, frame pulse and wrapping event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd        <= 4'd0;
            r_frame_done <= 1'b0;
            r_issued_cnt <= '0;
            r_frame_cnt  <= '0;
        end else begin
            if (w_issue_load) begin
                r_cmd <= w_head;
            end
            r_frame_done <= w_frame_end;
            if (r_state == S_ISSUE) begin
                r_issued_cnt <= r_issued_cnt + c_CNT_ONE;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_cmd_seq
//  Purpose  : Self-checking bench for lcd_cmd_seq. A behavioural LCD_CTRL
//             responder drives busy/done; issued commands are logged and
//             compared against a queue-based expectation of the FIFO order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_seq;

    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXC  = 65536;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         host_cmd = 4'd0;
    logic               host_push = 1'b0;
    logic               host_full;
    logic [CW-1:0]      host_count;
    logic               overflow;
    logic [3:0]         cmd;
    logic               cmd_valid;
    logic               busy;
    logic               done;
    logic               frame_done;
    logic [CNT_W-1:0]   issued_cnt;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder controls, written only by the main thread.
    bit force_busy  = 1'b1;
    bit toggle_busy = 1'b0;
    bit auto_done   = 1'b0;
    int clr_req     = 0;
    int done_req    = 0;

    // Observation logs, written only by the responder.
    int         cyc;
    logic [3:0] iss_code[$];
    int         iss_cyc[$];
    int         fd_cyc[$];
    int         done_cyc[$];
    bit         busy_hist [MAXC];

    lcd_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .host_cmd    (host_cmd),
        .host_push   (host_push),
        .host_full   (host_full),
        .host_count  (host_count),
        .overflow    (overflow),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .busy        (busy),
        .done        (done),
        .frame_done  (frame_done),
        .issued_cnt  (issued_cnt),
        .frame_cnt   (frame_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // LCD_CTRL stand-in: logs outputs at each falling edge, then drives
    // busy/done for the next rising edge.
    initial begin : lcd_model
        int clr_seen;
        int done_seen;
        int busy_left;
        int done_left;
        clr_seen = 0; done_seen = 0; busy_left = 0; done_left = 0;
        busy = 1'b1; done = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                iss_code.push_back(cmd);
                iss_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (clr_req != clr_seen) begin
                clr_seen  = clr_req;
                busy_left = 0;
                done_left = 0;
            end
            done = 1'b0;
            if (busy_left > 0) busy_left--;
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) done = 1'b1;
            end
            if (done_req != done_seen) begin
                done_seen = done_req;
                done = 1'b1;
            end
            if (cmd_valid && !reset) begin
                busy_left = $urandom_range(2, 6);
                if (cmd == 4'd0 && auto_done) done_left = $urandom_range(3, 12);
            end
            if (force_busy)       busy = 1'b1;
            else if (toggle_busy) busy = ~busy;
            else                  busy = (busy_left > 0);
            if (done) done_cyc.push_back(cyc);
            if (cyc < MAXC) busy_hist[cyc] = busy;
            cyc++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic bit is_legal(input logic [3:0] c);
        int max_code;
`ifdef CMD_FILTER_EN
        max_code = 11;
`else
        max_code = 15;
`endif
        return (int'(c) <= max_code);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] c);
        host_cmd  = c;
        host_push = 1'b1;
        tick(1);
        host_push = 1'b0;
    endtask

    task automatic do_reset(input bit fb);
        reset       = 1'b1;
        force_busy  = fb;
        toggle_busy = 1'b0;
        auto_done   = 1'b0;
        clr_req++;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_issues(input int target, input int limit, output bit ok);
        int k = 0;
        while (iss_code.size() < target && k < limit) begin
            tick(1);
            k++;
        end
        ok = (iss_code.size() >= target);
    endtask

    task automatic test_reset;
        do_reset(1'b1);
        n_tests++; if (cmd !== 4'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %0b expected 0", cmd_valid); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_tests++; if (host_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", host_full); end
        n_tests++; if (host_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", host_count); end
        n_tests++; if ({issued_cnt, frame_cnt, illegal_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", issued_cnt, frame_cnt, illegal_cnt);
        end
    endtask

    task automatic test_basic_issue;
        logic [3:0] exp_codes [3];
        int  base;
        int  c;
        bit  ok;
        bit  seen_busy;
        exp_codes[0] = 4'd3; exp_codes[1] = 4'd1; exp_codes[2] = 4'd0;
        do_reset(1'b1);
        base = iss_code.size();
        push(4'd3); push(4'd1); push(4'd0);
        tick(17);
        n_tests++; if (iss_code.size() != base) begin n_fail++; $display("FAIL busy_hold: got %0d issues expected 0", iss_code.size() - base); end
        n_tests++; if (host_count !== CW'(3)) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", host_count); end
        force_busy = 1'b0;
        wait_issues(base + 3, 300, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_wait: got %0d issues expected 3", iss_code.size() - base); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                c = iss_cyc[base + i];
                n_tests++; if (iss_code[base + i] !== exp_codes[i]) begin
                    n_fail++; $display("FAIL basic_code%0d: got %0d expected %0d", i, iss_code[base + i], exp_codes[i]);
                end
                n_tests++; if (busy_hist[c - 1] !== 1'b0) begin
                    n_fail++; $display("FAIL basic_issue_while_busy%0d: got busy=1 expected busy=0", i);
                end
                if (i > 0) begin
                    seen_busy = 1'b0;
                    for (int k = iss_cyc[base + i - 1]; k < c; k++) if (busy_hist[k]) seen_busy = 1'b1;
                    n_tests++; if ((c - iss_cyc[base + i - 1] < 2) || !seen_busy) begin
                        n_fail++; $display("FAIL basic_spacing%0d: got gap %0d busy_seen %0b expected gap>=2 busy_seen 1", i, c - iss_cyc[base + i - 1], seen_busy);
                    end
                end
            end
        end
        tick(3);
        n_tests++; if (issued_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL basic_issued_cnt: got %0d expected 3", issued_cnt); end
    endtask

    task automatic test_frame_wait;
        int base;
        int fbase;
        bit ok;
        base  = iss_code.size();
        fbase = fd_cyc.size();
        push(4'd9);
        toggle_busy = 1'b1;
        tick(50);
        toggle_busy = 1'b0;
        n_tests++; if (iss_code.size() != base) begin n_fail++; $display("FAIL frame_hold: got %0d issues expected 0", iss_code.size() - base); end
        n_tests++; if (fd_cyc.size() != fbase || frame_cnt !== '0) begin
            n_fail++; $display("FAIL frame_early: got pulses %0d cnt %0d expected 0 0", fd_cyc.size() - fbase, frame_cnt);
        end
        done_req++;
        tick(3);
        n_tests++; if (fd_cyc.size() != fbase + 1 || done_cyc.size() == 0) begin
            n_fail++; $display("FAIL frame_pulse_count: got %0d expected 1", fd_cyc.size() - fbase);
        end else if (fd_cyc[fd_cyc.size() - 1] != done_cyc[done_cyc.size() - 1] + 1) begin
            n_fail++; $display("FAIL frame_pulse_latency: got %0d expected 1", fd_cyc[fd_cyc.size() - 1] - done_cyc[done_cyc.size() - 1]);
        end
        n_tests++; if (frame_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL frame_cnt: got %0d expected 1", frame_cnt); end
        wait_issues(base + 1, 100, ok);
        n_tests++; if (!ok || iss_code[base] !== 4'd9) begin
            n_fail++; $display("FAIL frame_next_issue: got %0d expected 9", ok ? iss_code[base] : 4'hx);
        end
    endtask

    task automatic test_stray_done;
        int fbase;
        tick(20);
        fbase = fd_cyc.size();
        done_req++;
        tick(5);
        n_tests++; if (fd_cyc.size() != fbase || frame_cnt !== CNT_W'(1)) begin
            n_fail++; $display("FAIL stray_done: got pulses %0d cnt %0d expected 0 1", fd_cyc.size() - fbase, frame_cnt);
        end
    endtask

    task automatic test_overflow;
        logic [3:0] codes[$];
        logic [3:0] c;
        int base;
        bit ok;
        do_reset(1'b1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            c = 4'($urandom_range(0, 11));
            codes.push_back(c);
            host_cmd  = c;
            host_push = 1'b1;
            tick(1);
        end
        host_push = 1'b0;
        tick(1);
        n_tests++; if (host_full !== 1'b1 || host_count !== CW'(DEPTH)) begin
            n_fail++; $display("FAIL ovf_full: got full %0b count %0d expected 1 %0d", host_full, host_count, DEPTH);
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        base = iss_code.size();
        auto_done  = 1'b1;
        force_busy = 1'b0;
        wait_issues(base + DEPTH, 3000, ok);
        tick(40);
        n_tests++; if (!ok || iss_code.size() != base + DEPTH) begin
            n_fail++; $display("FAIL ovf_issue_count: got %0d expected %0d", iss_code.size() - base, DEPTH);
        end
        if (ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                n_tests++; if (iss_code[base + i] !== codes[i]) begin
                    n_fail++; $display("FAIL ovf_order%0d: got %0d expected %0d", i, iss_code[base + i], codes[i]);
                end
            end
        end
    endtask

    task automatic test_simul_push_pop;
        logic [3:0] exp_a [6];
        int base;
        bit ok;
        // Occupancy 5: push and pop land on the same edge.
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_a[i] = 4'(i + 1);
            push(4'(i + 1));
        end
        exp_a[5] = 4'd10;
        n_tests++; if (host_count !== CW'(5)) begin n_fail++; $display("FAIL simul_prefill: got %0d expected 5", host_count); end
        base = iss_code.size();
        force_busy = 1'b0;
        tick(1);
        push(4'd10);
        n_tests++; if (host_count !== CW'(5) || cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL simul_count: got count %0d valid %0b expected 5 1", host_count, cmd_valid);
        end
        wait_issues(base + 6, 300, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL simul_drain: got %0d expected 6", iss_code.size() - base); end
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                n_tests++; if (iss_code[base + i] !== exp_a[i]) begin
                    n_fail++; $display("FAIL simul_order%0d: got %0d expected %0d", i, iss_code[base + i], exp_a[i]);
                end
            end
        end
        // Full FIFO: a same-cycle pop does not make room for the push.
        do_reset(1'b1);
        for (int i = 0; i < DEPTH; i++) push(4'((i % 11) + 1));
        n_tests++; if (host_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_prefill: got full %0b ovf %0b expected 1 0", host_full, overflow);
        end
        base = iss_code.size();
        force_busy = 1'b0;
        auto_done  = 1'b1;
        tick(1);
        push(4'd0);
        n_tests++; if (host_count !== CW'(DEPTH - 1) || overflow !== 1'b1 || cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_pushpop: got count %0d ovf %0b valid %0b expected %0d 1 1", host_count, overflow, cmd_valid, DEPTH - 1);
        end
        wait_issues(base + DEPTH, 1000, ok);
        tick(30);
        n_tests++; if (!ok || iss_code.size() != base + DEPTH || host_count !== '0) begin
            n_fail++; $display("FAIL full_drain: got %0d issues count %0d expected %0d 0", iss_code.size() - base, host_count, DEPTH);
        end
        if (ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                n_tests++; if (iss_code[base + i] !== 4'((i % 11) + 1)) begin
                    n_fail++; $display("FAIL full_order%0d: got %0d expected %0d", i, iss_code[base + i], (i % 11) + 1);
                end
            end
        end
    endtask

    task automatic test_filter;
        int base;
        bit ok;
        do_reset(1'b1);
        base = iss_code.size();
        push(4'hE);
        push(4'd5);
        force_busy = 1'b0;
`ifdef CMD_FILTER_EN
        wait_issues(base + 1, 200, ok);
        tick(20);
        n_tests++; if (!ok || iss_code.size() != base + 1 || iss_code[base] !== 4'd5) begin
            n_fail++; $display("FAIL filter_issue: got %0d issues expected 1 (code 5)", iss_code.size() - base);
        end
        n_tests++; if (illegal_cnt !== CNT_W'(1) || issued_cnt !== CNT_W'(1)) begin
            n_fail++; $display("FAIL filter_counts: got ill %0d iss %0d expected 1 1", illegal_cnt, issued_cnt);
        end
`else
        wait_issues(base + 2, 200, ok);
        tick(20);
        n_tests++; if (!ok || iss_code.size() != base + 2 || iss_code[base] !== 4'hE || iss_code[base + 1] !== 4'd5) begin
            n_fail++; $display("FAIL filter_issue: got %0d issues expected 2 (codes 14,5)", iss_code.size() - base);
        end
        n_tests++; if (illegal_cnt !== '0 || issued_cnt !== CNT_W'(2)) begin
            n_fail++; $display("FAIL filter_counts: got ill %0d iss %0d expected 0 2", illegal_cnt, issued_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        do_reset(1'b1);
        push(4'd0); push(4'd2); push(4'd3); push(4'd4); push(4'd6);
        base = iss_code.size();
        force_busy = 1'b0;
        wait_issues(base + 1, 100, ok);
        tick(4);
        n_tests++; if (!ok || host_count !== CW'(4)) begin
            n_fail++; $display("FAIL rstmid_setup: got count %0d expected 4", host_count);
        end
        reset = 1'b1;
        clr_req++;
        tick(1);
        n_tests++; if ({cmd, cmd_valid, frame_done, overflow, host_full} !== '0 || host_count !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got cmd %0d v %0b fd %0b ovf %0b full %0b count %0d expected all 0",
                               cmd, cmd_valid, frame_done, overflow, host_full, host_count);
        end
        n_tests++; if ({issued_cnt, frame_cnt, illegal_cnt} !== '0) begin
            n_fail++; $display("FAIL rstmid_counters: got %0d/%0d/%0d expected 0/0/0", issued_cnt, frame_cnt, illegal_cnt);
        end
        reset = 1'b0;
        base = iss_code.size();
        tick(30);
        n_tests++; if (iss_code.size() != base || host_count !== '0) begin
            n_fail++; $display("FAIL rstmid_quiet: got %0d issues count %0d expected 0 0", iss_code.size() - base, host_count);
        end
        push(4'd7);
        wait_issues(base + 1, 100, ok);
        n_tests++; if (!ok || iss_code[base] !== 4'd7) begin
            n_fail++; $display("FAIL rstmid_resume: got %0d issues expected code 7", iss_code.size() - base);
        end
    endtask

    task automatic test_random;
        int exp_iss;
        int exp_fr;
        int exp_ill;
        do_reset(1'b0);
        auto_done = 1'b1;
        exp_iss = 0; exp_fr = 0; exp_ill = 0;
        for (int r = 0; r < 8; r++) begin
            logic [3:0] exp_q[$];
            logic [3:0] c;
            int  n;
            int  zeros;
            int  base;
            int  fbase;
            bit  ok;
            n = $urandom_range(1, DEPTH);
            zeros = 0;
            base  = iss_code.size();
            fbase = fd_cyc.size();
            for (int i = 0; i < n; i++) begin
                c = 4'($urandom_range(0, 15));
                if (is_legal(c)) begin
                    exp_q.push_back(c);
                    if (c == 4'd0) zeros++;
                end else begin
                    exp_ill++;
                end
                push(c);
                tick($urandom_range(0, 3));
            end
            wait_issues(base + exp_q.size(), 4000, ok);
            tick(40);
            exp_iss += exp_q.size();
            exp_fr  += zeros;
            n_tests++; if (!ok || iss_code.size() != base + exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_issue_count: got %0d expected %0d", r, iss_code.size() - base, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_tests++; if (iss_code[base + i] !== exp_q[i] || busy_hist[iss_cyc[base + i] - 1] !== 1'b0) begin
                        n_fail++; $display("FAIL rand%0d_issue%0d: got code %0d busy %0b expected code %0d busy 0",
                                           r, i, iss_code[base + i], busy_hist[iss_cyc[base + i] - 1], exp_q[i]);
                    end
                end
            end
            n_tests++; if (issued_cnt !== CNT_W'(exp_iss) || frame_cnt !== CNT_W'(exp_fr) || illegal_cnt !== CNT_W'(exp_ill)) begin
                n_fail++; $display("FAIL rand%0d_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   r, issued_cnt, frame_cnt, illegal_cnt, exp_iss % 256, exp_fr % 256, exp_ill % 256);
            end
            n_tests++; if (fd_cyc.size() - fbase != zeros || host_count !== '0 || overflow !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_state: got pulses %0d count %0d ovf %0b expected %0d 0 0",
                                   r, fd_cyc.size() - fbase, host_count, overflow, zeros);
            end
        end
    endtask

    initial begin : main
        test_reset();
        test_basic_issue();
        test_frame_wait();
        test_stray_done();
        test_overflow();
        test_simul_push_pop();
        test_filter();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer directly upstream of LCD_CTRL.
- Buffers 4-bit image-processing commands from a host or test sequencer in a FIFO.
- Issues them one at a time on LCD_CTRL's cmd/cmd_valid interface, obeying busy.
- After each Write command (code 0) it holds further issue until LCD_CTRL pulses done, then reports frame completion.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..64.
CNT_W, 8, width of issued/frame/illegal counters (wrap modulo 2^CNT_W).

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
host_cmd  in  4  command code to enqueue.
host_push  in  1  enqueue host_cmd this cycle.
host_full  out  1  FIFO full.
host_count  out  log2(DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky: push attempted while full.
cmd  out  4  command to LCD_CTRL.
cmd_valid  out  1  one-cycle strobe to LCD_CTRL.
busy  in  1  LCD_CTRL busy.
done  in  1  LCD_CTRL frame-written pulse.
frame_done  out  1  one-cycle pulse after done observed.
issued_cnt  out  CNT_W  commands issued.
frame_cnt  out  CNT_W  frames completed.
illegal_cnt  out  CNT_W  commands dropped as illegal (see Optional Feature).

Behaviour:
- Reset values: cmd=0, cmd_valid=0, frame_done=0, overflow=0, all counters 0, FIFO empty, host_full=0, host_count=0, state=IDLE. Reset mid-operation discards queued and in-flight commands immediately.
- FIFO: circular buffer, registered pointers.
  - Push is accepted iff host_push=1 and host_full=0, both sampled at the start of the cycle. A same-cycle pop does not free space for that push.
  - A push while full is dropped and sets overflow; overflow clears only on reset.
  - Simultaneous accepted push and pop leaves host_count unchanged.
- States: IDLE, ISSUE, SETTLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if FIFO non-empty and busy=0, pop head into cmd -> ISSUE. Otherwise stay. After reset LCD_CTRL is busy loading IROM; the block waits here.
  - ISSUE: cmd_valid=1 for exactly this cycle; issued_cnt+1 -> SETTLE.
  - SETTLE: one dead cycle, cmd_valid=0. Covers LCD_CTRL raising busy one cycle after acceptance. If cmd==0 -> WAIT_DONE, else -> WAIT_BUSY.
  - WAIT_BUSY: when busy=0 -> IDLE. Next issue is therefore at least 1 cycle after busy falls.
  - WAIT_DONE: ignore busy; when done=1 -> frame_done=1 next cycle, frame_cnt+1 -> IDLE. No timeout.
- cmd holds its last issued value outside ISSUE.
- Legal codes are 0x0..0xB: write, shift up/down/left/right, max, min, average, rotate CCW/CW, mirror X/Y.
- done arriving outside WAIT_DONE is ignored: no pulse, no count.
- All counters wrap silently.

Optional Feature:
Macro CMD_FILTER_EN.
- Defined: a popped code 0xC..0xF is not issued. The pop still occurs, illegal_cnt+1, state stays IDLE, and the next entry may pop the following cycle. issued_cnt is not incremented.
- Undefined: all codes are forwarded verbatim and illegal_cnt is tied to 0.

Test Plan:
- Reset, busy=1 for 20 cycles, push 3,1,0 -> no cmd_valid while busy; after busy falls, cmd_valid pulses carry 3, then 1, then 0. Each pulse is single-cycle, and consecutive pulses are separated by the busy window plus at least 1 cycle. issued_cnt=3.
- After code 0 issued, hold done=0 for 50 cycles with busy toggling -> no further cmd_valid. Pulse done -> frame_done exactly 1 cycle later, frame_cnt=1, next queued command issues.
- Push DEPTH+2 commands while busy=1 -> host_full=1, host_count=DEPTH, overflow=1. Only the first DEPTH commands are issued, in order.
- Push and pop in the same cycle at occupancy 5 -> host_count stays 5. Push at full with simultaneous pop -> push dropped, overflow=1.
- With CMD_FILTER_EN defined, push 0xE,5 -> only 5 issued, illegal_cnt=1. Without the macro -> 0xE issued, illegal_cnt=0.
- Assert reset while in WAIT_DONE with 4 entries queued -> next cycle all outputs at reset values, host_count=0, and no cmd_valid until new pushes arrive.
